id_exe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the ID/EXE pipeline register and the EXE-stage functional units. Each cycle it decides whether the front end (PC, IF/ID) advances or stalls, whether a bubble (all-zero control word) goes into ID/EXE, and whether IF/ID is flushed. It resolves load-use hazards, taken branches and jumps resolved in EXE, and multi-cycle EXE operations (integer mult/div, FP). It sits beside the ID/EXE register and drives its bubble and hold controls and the PC and IF/ID write enables.

---
 rtl/id_exe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_id_exe_hazard_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/id_exe_hazard_ctrl.sv
// ID/EXE sequencing controller: load-use stalls, EXE-resolved redirects and
// multi-cycle EXE occupancy (integer mult/div and FP) with a stall-cycle counter.
module id_exe_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int FP_LAT  = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        uses_Rs_ID,
  input  logic        uses_Rt_ID,
  input  logic        multicycle_ID,
  input  logic        FP_ID,
  input  logic        MemRead_EXE,
  input  logic [4:0]  Rt_EXE,
  input  logic        branch_taken_EXE,
  input  logic        jump_EXE,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        bubble_ID_EXE,
  output logic        flush_IF_ID,
  output logic        ex_hold,
  output logic        mc_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] MDU_LAT_C = 4'(MDU_LAT);
  localparam logic [3:0] FP_LAT_C  = 4'(FP_LAT);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [15:0] stall_cycles_r;

  logic        lu_s;
  logic        rd_s;
  logic        mc_entry_s;
  logic [3:0]  lat_s;
  logic        pc_write_s;
  logic        if_id_write_s;
  logic        bubble_s;
  logic        flush_s;
  logic        busy_s;

  function automatic logic src_hit(input logic uses, input logic [4:0] src,
                                   input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

  // Hazard detection and multi-cycle entry decode
  always_comb begin
    lu_s = MemRead_EXE && (Rt_EXE != 5'd0) &&
           (src_hit(uses_Rs_ID, Rs_ID, Rt_EXE) || src_hit(uses_Rt_ID, Rt_ID, Rt_EXE));
    rd_s = branch_taken_EXE || jump_EXE;
    if (FP_ID) begin
      lat_s = FP_LAT_C;
    end else begin
      lat_s = MDU_LAT_C;
    end
    mc_entry_s = (state_r == RUN) && !rd_s && !lu_s && multicycle_ID;
  end

  // Pipeline control outputs; redirect dominates load-use while in RUN
  always_comb begin
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    bubble_s      = 1'b0;
    flush_s       = 1'b0;
    busy_s        = 1'b0;
    if (Rst) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      bubble_s      = 1'b1;
      flush_s       = 1'b1;
    end else if (state_r == MC_BUSY) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      busy_s        = 1'b1;
    end else if (rd_s) begin
      bubble_s      = 1'b1;
      flush_s       = 1'b1;
    end else if (lu_s) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      bubble_s      = 1'b1;
    end else begin
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
    end
  end

  assign PC_write      = pc_write_s;
  assign IF_ID_write   = if_id_write_s;
  assign bubble_ID_EXE = bubble_s;
  assign flush_IF_ID   = flush_s;
  assign ex_hold       = busy_s;
  assign mc_busy       = busy_s;
  assign stall_cycles  = stall_cycles_r;

  // Sequencing FSM; cnt holds the busy cycles still owed after the entry edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (mc_entry_s && (lat_s > 4'd1)) begin
            state_r <= MC_BUSY;
            cnt_r   <= lat_s - 4'd1;
          end else begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
          end
        end
        MC_BUSY: begin
          if (cnt_r <= 4'd1) begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
          end else begin
            state_r <= MC_BUSY;
            cnt_r   <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Saturating count of front-end stall cycles
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cycles_r <= 16'd0;
    end else if (!pc_write_s && (stall_cycles_r != 16'hFFFF)) begin
      stall_cycles_r <= stall_cycles_r + 16'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

endmodule

// File: tb/tb_id_exe_hazard_ctrl.sv
// Directed bench for id_exe_hazard_ctrl: expected control words and stall
// counts are queued with each stimulus step and compared mid-cycle.
module tb_id_exe_hazard_ctrl;

  logic        Clk;
  logic        Rst;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic        uses_Rs_ID;
  logic        uses_Rt_ID;
  logic        multicycle_ID;
  logic        FP_ID;
  logic        MemRead_EXE;
  logic [4:0]  Rt_EXE;
  logic        branch_taken_EXE;
  logic        jump_EXE;
  logic        PC_write;
  logic        IF_ID_write;
  logic        bubble_ID_EXE;
  logic        flush_IF_ID;
  logic        ex_hold;
  logic        mc_busy;
  logic [15:0] stall_cycles;

  // {PC_write, IF_ID_write, bubble_ID_EXE, flush_IF_ID, ex_hold, mc_busy}
  localparam logic [5:0] C_N  = 6'b110000;
  localparam logic [5:0] C_LU = 6'b001000;
  localparam logic [5:0] C_RD = 6'b111100;
  localparam logic [5:0] C_BZ = 6'b000011;
  localparam logic [5:0] C_RS = 6'b001100;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [15:0] stall;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;
  int   step_no = 0;

  id_exe_hazard_ctrl #(.MDU_LAT(4), .FP_LAT(1)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Rs_ID            (Rs_ID),
    .Rt_ID            (Rt_ID),
    .uses_Rs_ID       (uses_Rs_ID),
    .uses_Rt_ID       (uses_Rt_ID),
    .multicycle_ID    (multicycle_ID),
    .FP_ID            (FP_ID),
    .MemRead_EXE      (MemRead_EXE),
    .Rt_EXE           (Rt_EXE),
    .branch_taken_EXE (branch_taken_EXE),
    .jump_EXE         (jump_EXE),
    .PC_write         (PC_write),
    .IF_ID_write      (IF_ID_write),
    .bubble_ID_EXE    (bubble_ID_EXE),
    .flush_IF_ID      (flush_IF_ID),
    .ex_hold          (ex_hold),
    .mc_busy          (mc_busy),
    .stall_cycles     (stall_cycles)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic drive(input logic rst, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic mr,
                       input logic [4:0] rte, input logic mc, input logic fp,
                       input logic br, input logic jp);
    Rst = rst;
    Rs_ID = rs;
    uses_Rs_ID = urs;
    Rt_ID = rt;
    uses_Rt_ID = urt;
    MemRead_EXE = mr;
    Rt_EXE = rte;
    multicycle_ID = mc;
    FP_ID = fp;
    branch_taken_EXE = br;
    jump_EXE = jp;
  endtask

  task automatic compare_front();
    exp_t e;
    logic [5:0] got;
    e = sb_q.pop_front();
    got = {PC_write, IF_ID_write, bubble_ID_EXE, flush_IF_ID, ex_hold, mc_busy};
    total++;
    assert (got === e.ctl) passed++;
    else $error("FAIL ctl step %0d got %b want %b", step_no, got, e.ctl);
    total++;
    assert (stall_cycles === e.stall) passed++;
    else $error("FAIL stall step %0d got %0d want %0d", step_no, stall_cycles, e.stall);
  endtask

  task automatic cyc(input logic rst, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt, input logic mr,
                     input logic [4:0] rte, input logic mc, input logic fp,
                     input logic br, input logic jp,
                     input logic [5:0] ctl, input logic [15:0] st);
    exp_t e;
    @(negedge Clk);
    step_no++;
    drive(rst, rs, urs, rt, urt, mr, rte, mc, fp, br, jp);
    e.ctl = ctl;
    e.stall = st;
    sb_q.push_back(e);
    #2;
    compare_front();
  endtask

  initial begin
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    //   rst   rs     urs   rt     urt   mr    rte    mc    fp    br    jp    ctl   stall
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RS, 16'd0);
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RS, 16'd0);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_N,  16'd0);
    // load-use on Rs, then the load is gone
    cyc(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 16'd0);
    cyc(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_N,  16'd1);
    // $zero never stalls
    cyc(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_N,  16'd1);
    // load-use on Rt, then matching regs with use flags off
    cyc(1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 16'd1);
    cyc(1'b0, 5'd9, 1'b0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_N,  16'd2);
    // branch beats load-use and kills a multi-cycle op; then a jump
    cyc(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, C_RD, 16'd2);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_RD, 16'd2);
    // MDU op (LAT 4): hazards ignored while busy, second op queued behind it
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_N,  16'd2);
    cyc(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, C_BZ, 16'd2);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_BZ, 16'd3);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_BZ, 16'd4);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_N,  16'd5);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_BZ, 16'd5);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_BZ, 16'd6);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_BZ, 16'd7);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_N,  16'd8);
    // FP op with LAT 1 never enters MC_BUSY
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_N,  16'd8);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_N,  16'd8);
    // load then dependent MDU op: one lu stall, then entry
    cyc(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 16'd8);
    cyc(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_N,  16'd9);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_BZ, 16'd9);
    // reset in the second busy cycle aborts the op
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RS, 16'd10);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_N,  16'd0);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_N,  16'd0);
    // hold a load-use long enough to saturate the stall counter
    for (int i = 0; i < 65540; i++) begin
      @(negedge Clk);
      drive(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 16'hFFFF);
    cyc(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 16'hFFFF);
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RS, 16'hFFFF);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_N,  16'd0);
    total++;
    assert (sb_q.size() == 0) passed++;
    else $error("FAIL sb_drain got %0d entries want 0", sb_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
